seq_bin2bcd: RTL



---
 rtl/bcd_pkg.sv | 33 +++
 rtl/bcd_digit_adj.sv | 18 +
 rtl/seq_bin2bcd.sv | 125 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared constants, FSM encoding and parameter-check helper for
//               the sequential binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] ADJ_VAL    = 4'd3;

    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_IDLE  = 1'b0;
    localparam logic [STATE_W-1:0] ST_SHIFT = 1'b1;

    // Decimal digits needed to represent the largest BIN_W-bit unsigned value.
    function automatic int min_digits(input int bin_w);
        longint unsigned max_val;
        int              d;
        max_val = (64'd1 << bin_w) - 64'd1;
        d       = 1;
        while (max_val >= 64'd10) begin
            max_val = max_val / 64'd10;
            d       = d + 1;
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Combinational add-3 correction cell for one BCD digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    // 4-bit add wraps mod 16 for the unreachable codes 10..15.
    assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit + ADJ_VAL) : i_digit;

endmodule
`default_nettype wire

// File: rtl/seq_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : seq_bin2bcd
// Description : Sequential double-dabble binary-to-BCD converter, one shift per
//               clock, with start/busy/done handshake and registered result.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_bin2bcd
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BIN_W-1:0]       bin,
    output logic                   busy,
    output logic                   done,
    output logic [4*DIGITS-1:0]    bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BIN_W - 1);

    generate
        if (DIGITS < min_digits(BIN_W)) begin : g_param_check
            $error("seq_bin2bcd: DIGITS too small for BIN_W");
        end
    endgenerate

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_shift;
    logic [BCD_W-1:0]   r_scratch;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_busy;
    logic               r_done;

    logic               w_load;
    logic               w_shift_en;
    logic               w_last;
    logic [BCD_W-1:0]   w_corr;
    logic [BCD_W-1:0]   w_shifted;
    logic               w_unused_msb;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_adj u_adj (
                .i_digit (r_scratch[g*DIGIT_W +: DIGIT_W]),
                .o_digit (w_corr[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // The corrected top bit falls off the end of the shift.
    assign w_shifted    = {w_corr[BCD_W-2:0], r_shift[BIN_W-1]};
    assign w_unused_msb = w_corr[BCD_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_cnt == C_LAST) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load     = 1'b0;
        w_shift_en = 1'b0;
        w_last     = 1'b0;
        case (r_state)
            ST_IDLE:  w_load = start;
            ST_SHIFT: begin
                w_shift_en = 1'b1;
                w_last     = (r_cnt == C_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_shift   <= bin;
                r_scratch <= '0;
                r_cnt     <= '0;
                r_busy    <= 1'b1;
            end else if (w_shift_en) begin
                r_scratch <= w_shifted;
                r_shift   <= r_shift << 1;
                r_cnt     <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_bcd  <= w_shifted;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule
`default_nettype wire
